divider_n_seq: RTL and testbench

DIVIDER_N_SEQ -- requirements
Module: divider_n_seq

---
 rtl/divider_n_seq.sv | 118 +++++++++++
 tb/tb_divider_n_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_n_seq.sv
// divider_n_seq: sequential restoring unsigned divider, one quotient bit per clock.
// Handshake: Start in QI launches a division, Done/Qd marks the result, Ack in QD returns to QI.
// Optional build macro DIVN_EARLY_EXIT_EN: when Xin < Yin, skip QC and finish one edge after Start.
module divider_n_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] Xin,
  input  logic [WIDTH-1:0] Yin,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // One-hot encoding, so each state bit can drive its LED directly.
  typedef enum logic [2:0] {
    QI = 3'b001,
    QC = 3'b010,
    QD = 3'b100
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_reg;    // dividend bits shift out MSB-first, quotient bits shift in at the LSB
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   partial_c;
  logic [WIDTH-1:0] diff_c;
  logic             q_bit_c;
  logic [WIDTH-1:0] rem_next_c;
  logic [WIDTH-1:0] quo_next_c;

  // One restoring shift-subtract step on the current partial remainder.
  always_comb begin
    partial_c  = {rem_reg, x_reg[WIDTH-1]};
    diff_c     = partial_c[WIDTH-1:0] - y_reg;
    q_bit_c    = (partial_c >= {1'b0, y_reg});
    rem_next_c = q_bit_c ? diff_c : partial_c[WIDTH-1:0];
    quo_next_c = {x_reg[WIDTH-2:0], q_bit_c};
  end

  // State indicators come straight from the state register bits.
  assign Qi   = state[0];
  assign Qc   = state[1];
  assign Qd   = state[2];
  assign Done = state[2];

  // Control FSM and datapath registers; results load only on entry to QD.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state     <= QI;
      x_reg     <= '0;
      y_reg     <= '0;
      rem_reg   <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        QI: begin
          if (Start) begin
            x_reg     <= Xin;
            y_reg     <= Yin;
            rem_reg   <= '0;
            count     <= '0;
            DivByZero <= 1'b0;
            if (Yin == '0) begin
              state     <= QD;
              DivByZero <= 1'b1;
              Quotient  <= '1;
              Remainder <= Xin;
            end
`ifdef DIVN_EARLY_EXIT_EN
            else if (Xin < Yin) begin
              state     <= QD;
              Quotient  <= '0;
              Remainder <= Xin;
            end
`endif
            else begin
              state <= QC;
            end
          end
        end
        QC: begin
          x_reg   <= quo_next_c;
          rem_reg <= rem_next_c;
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= QD;
            Quotient  <= quo_next_c;
            Remainder <= rem_next_c;
          end
        end
        QD: begin
          if (Ack) begin
            state <= QI;
          end
        end
        default: begin
          state <= QI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_n_seq.sv
// Directed bench for divider_n_seq: an 8-bit and a 16-bit instance share clock and reset.
module tb_divider_n_seq;

  logic        board_clk;
  logic        Reset;

  logic        start8, ack8;
  logic [7:0]  x8, y8, q8, r8;
  logic        done8, qi8, qc8, qd8, dz8;

  logic        start16, ack16;
  logic [15:0] x16, y16, q16, r16;
  logic        done16, qi16, qc16, qd16, dz16;

  int compared   = 0;
  int mismatched = 0;

  divider_n_seq #(.WIDTH(8)) u_div8 (
    .board_clk (board_clk),
    .Reset     (Reset),
    .Start     (start8),
    .Ack       (ack8),
    .Xin       (x8),
    .Yin       (y8),
    .Quotient  (q8),
    .Remainder (r8),
    .Done      (done8),
    .Qi        (qi8),
    .Qc        (qc8),
    .Qd        (qd8),
    .DivByZero (dz8)
  );

  divider_n_seq #(.WIDTH(16)) u_div16 (
    .board_clk (board_clk),
    .Reset     (Reset),
    .Start     (start16),
    .Ack       (ack16),
    .Xin       (x16),
    .Yin       (y16),
    .Quotient  (q16),
    .Remainder (r16),
    .Done      (done16),
    .Qi        (qi16),
    .Qc        (qc16),
    .Qd        (qd16),
    .DivByZero (dz16)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  // Advance one rising edge and settle away from it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state8(input string tag, input logic [2:0] exp_dci);
    check(tag, {29'd0, qd8, qc8, qi8}, {29'd0, exp_dci});
  endtask

  initial begin
    Reset   = 1'b0;
    start8  = 1'b0; ack8  = 1'b0; x8  = '0; y8  = '0;
    start16 = 1'b0; ack16 = 1'b0; x16 = '0; y16 = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 Reset = 1'b1;
    #1;
    check_state8("rst_state", 3'b001);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_dz",   {31'd0, dz8},   32'd0);
    check("rst_q",    {24'd0, q8},    32'd0);
    check("rst_r",    {24'd0, r8},    32'd0);
    check("rst_q16",  {16'd0, q16},   32'd0);
    tick(2);
    Reset = 1'b0;
    tick(1);

    // Ack in QI is ignored.
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;
    check_state8("ack_in_qi", 3'b001);

    // 200 / 7 = 28 rem 4, Done after 8 edges.
    x8 = 8'd200; y8 = 8'd7; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    x8 = 8'd99; y8 = 8'd3;            // must not disturb the running division
    check_state8("d200_qc", 3'b010);
    tick(7);
    check("d200_not_done", {31'd0, done8}, 32'd0);
    check("d200_q_hold",   {24'd0, q8},    32'd0);
    tick(1);
    check("d200_done", {31'd0, done8}, 32'd1);
    check_state8("d200_qd", 3'b100);
    check("d200_q",  {24'd0, q8},  32'h1C);
    check("d200_r",  {24'd0, r8},  32'h04);
    check("d200_dz", {31'd0, dz8}, 32'd0);
    tick(3);
    check_state8("d200_wait", 3'b100);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;
    check_state8("d200_ack", 3'b001);
    check("d200_q_in_qi", {24'd0, q8}, 32'h1C);
    check("d200_r_in_qi", {24'd0, r8}, 32'h04);

    // 5 / 0: straight to QD in one edge with the divide-by-zero result.
    x8 = 8'd5; y8 = 8'd0; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    check_state8("dz_qd", 3'b100);
    check("dz_q",  {24'd0, q8},  32'hFF);
    check("dz_r",  {24'd0, r8},  32'h05);
    check("dz_dz", {31'd0, dz8}, 32'd1);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;
    check_state8("dz_ack", 3'b001);

    // 3 / 9 = 0 rem 3; latency depends on the early-exit build.
    x8 = 8'd3; y8 = 8'd9; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    check("small_dz_clr", {31'd0, dz8}, 32'd0);
`ifdef DIVN_EARLY_EXIT_EN
    check("small_done", {31'd0, done8}, 32'd1);
`else
    check_state8("small_qc", 3'b010);
    tick(7);
    check("small_not_done", {31'd0, done8}, 32'd0);
    tick(1);
    check("small_done", {31'd0, done8}, 32'd1);
`endif
    check("small_q", {24'd0, q8}, 32'h00);
    check("small_r", {24'd0, r8}, 32'h03);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;

    // 255 / 1 with Start held high throughout; Ack withheld for 20 cycles.
    x8 = 8'd255; y8 = 8'd1; start8 = 1'b1;
    tick(1);
    check_state8("big_qc", 3'b010);
    tick(8);
    check("big_done", {31'd0, done8}, 32'd1);
    tick(20);
    check_state8("big_hold_qd", 3'b100);
    check("big_q", {24'd0, q8}, 32'hFF);
    check("big_r", {24'd0, r8}, 32'h00);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;
    check_state8("big_ack_qi", 3'b001);
    tick(1);
    check_state8("big_restart", 3'b010);
    start8 = 1'b0;
    tick(8);
    check("big2_done", {31'd0, done8}, 32'd1);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;

    // Reset during the 4th QC cycle of 200 / 7 aborts the division.
    x8 = 8'd200; y8 = 8'd7; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    tick(3);
    check_state8("abort_in_qc", 3'b010);
    Reset = 1'b1;
    #2;
    check_state8("abort_state", 3'b001);
    check("abort_q",    {24'd0, q8},    32'd0);
    check("abort_r",    {24'd0, r8},    32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    Reset = 1'b0;
    tick(3);
    check_state8("abort_wait_qi", 3'b001);
    check("abort_q_hold", {24'd0, q8}, 32'd0);

    // 100 / 10 = 10 rem 0 after the abort.
    x8 = 8'd100; y8 = 8'd10; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    tick(8);
    check("d100_done", {31'd0, done8}, 32'd1);
    check("d100_q", {24'd0, q8}, 32'h0A);
    check("d100_r", {24'd0, r8}, 32'h00);
    ack8 = 1'b1;
    tick(1);
    ack8 = 1'b0;

    // 16-bit: 65535 / 256 = 255 rem 255, Done after 16 edges.
    x16 = 16'd65535; y16 = 16'd256; start16 = 1'b1;
    tick(1);
    start16 = 1'b0;
    check("w16_qc", {31'd0, qc16}, 32'd1);
    tick(15);
    check("w16_not_done", {31'd0, done16}, 32'd0);
    tick(1);
    check("w16_done", {31'd0, done16}, 32'd1);
    check("w16_q",  {16'd0, q16}, 32'h00FF);
    check("w16_r",  {16'd0, r16}, 32'h00FF);
    check("w16_dz", {31'd0, dz16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
